piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order and a bit-rate strobe. It accepts a WIDTH-bit word and emits it one bit per enabled clock, framed by ser_valid and ser_last. It sits between a parallel datapath and a serial line driver, and supports back-to-back words with no idle gap.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_shift_reg.sv | 31 +++
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and constants for the PISO serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial line bundle for the PISO serializer
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_valid, in_data, shift_en,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data, shift_en,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - word holding register; exposes the first bit of a new word and the next bit to present
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             first_bit,
  output logic             next_bit
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    end
  end

  // The head bit is already on ser_out, so the bit to present next sits one position in.
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? sr[WIDTH-2] : sr[1];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer with gapless reload
// Optional even-parity trailer bit under `define PIS_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  piso_serializer_if.slave bus
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             advance;
  logic             first_bit;
  logic             next_bit;
`ifdef PIS_PARITY_EN
  logic             parity;
`endif

  // Ready during the last bit's consuming cycle lets the next word follow with no bubble.
  assign bus.in_ready = (state == IDLE) || (bus.ser_last && bus.shift_en);
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = (state == SHIFT) && bus.shift_en && !accept;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (advance),
    .load_data (bus.in_data),
    .first_bit (first_bit),
    .next_bit  (next_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bus.ser_out   <= IDLE_LEVEL;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
`ifdef PIS_PARITY_EN
      parity        <= 1'b0;
`endif
    end else if (accept) begin
      state         <= SHIFT;
      bit_cnt       <= '0;
      bus.ser_out   <= first_bit;
      bus.ser_valid <= 1'b1;
      bus.ser_last  <= 1'b0;
`ifdef PIS_PARITY_EN
      parity        <= ^bus.in_data;
`endif
    end else if (advance) begin
`ifdef PIS_PARITY_EN
      if (bit_cnt == LAST_CNT) begin
        state        <= PARITY;
        bit_cnt      <= '0;
        bus.ser_out  <= parity;
        bus.ser_last <= 1'b1;
      end else begin
        bit_cnt      <= bit_cnt + 1'b1;
        bus.ser_out  <= next_bit;
      end
`else
      if (bus.ser_last) begin
        state         <= IDLE;
        bit_cnt       <= '0;
        bus.ser_out   <= IDLE_LEVEL;
        bus.ser_valid <= 1'b0;
        bus.ser_last  <= 1'b0;
      end else begin
        bit_cnt       <= bit_cnt + 1'b1;
        bus.ser_out   <= next_bit;
        bus.ser_last  <= (bit_cnt == LAST_CNT - 1'b1);
      end
`endif
    end
`ifdef PIS_PARITY_EN
    else if ((state == PARITY) && bus.shift_en) begin
      state         <= IDLE;
      bus.ser_out   <= IDLE_LEVEL;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed bench for piso_serializer (MSB-first and LSB-first instances)
// Frame length follows `define PIS_PARITY_EN.
module tb_piso_serializer;

`ifdef PIS_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  piso_serializer_if #(.WIDTH(8)) m ();
  piso_serializer_if #(.WIDTH(8)) l ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (m.slave)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (l.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input bit msb, input int i);
    if (i >= 8) return ^w;
    return msb ? w[7 - i] : w[i];
  endfunction

  task automatic chk_m_idle(input string tag);
    chk({tag, ".valid"}, m.ser_valid, 1'b0);
    chk({tag, ".last"},  m.ser_last,  1'b0);
    chk({tag, ".out"},   m.ser_out,   1'b0);
    chk({tag, ".busy"},  m.busy,      1'b0);
    chk({tag, ".ready"}, m.in_ready,  1'b1);
  endtask

  // One full frame on the MSB-first instance with shift_en held high.
  task automatic m_frame(input string tag, input logic [7:0] w);
    m.in_valid = 1'b1;
    m.in_data  = w;
    m.shift_en = 1'b1;
    step();
    m.in_valid = 1'b0;
    m.in_data  = ~w;
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), m.ser_valid, 1'b1);
      chk($sformatf("%s.out%0d", tag, i),   m.ser_out,   exp_bit(w, 1'b1, i));
      chk($sformatf("%s.last%0d", tag, i),  m.ser_last,  (i == FRAME - 1));
      chk($sformatf("%s.ready%0d", tag, i), m.in_ready,  (i == FRAME - 1));
      chk($sformatf("%s.busy%0d", tag, i),  m.busy,      1'b1);
      step();
    end
    chk_m_idle({tag, ".end"});
    step();
    chk_m_idle({tag, ".idle_shift"});
    m.shift_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    m.in_valid = 1'b0;
    m.in_data  = '0;
    m.shift_en = 1'b0;
    l.in_valid = 1'b0;
    l.in_data  = '0;
    l.shift_en = 1'b0;

    #2;
    chk_m_idle("reset");
    chk("reset.lsb_valid", l.ser_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    m_frame("msb_a5", 8'hA5);

    // LSB first, each bit held one extra cycle with shift_en low.
    l.in_valid = 1'b1;
    l.in_data  = 8'hA5;
    l.shift_en = 1'b0;
    step();
    l.in_valid = 1'b0;
    l.in_data  = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("lsb.out%0d", i),   l.ser_out,   exp_bit(8'hA5, 1'b0, i));
      chk($sformatf("lsb.valid%0d", i), l.ser_valid, 1'b1);
      chk($sformatf("lsb.last%0d", i),  l.ser_last,  (i == FRAME - 1));
      l.shift_en = 1'b0;
      step();
      chk($sformatf("lsb.hold_out%0d", i),   l.ser_out,   exp_bit(8'hA5, 1'b0, i));
      chk($sformatf("lsb.hold_valid%0d", i), l.ser_valid, 1'b1);
      chk($sformatf("lsb.hold_last%0d", i),  l.ser_last,  (i == FRAME - 1));
      chk($sformatf("lsb.hold_ready%0d", i), l.in_ready,  1'b0);
      l.shift_en = 1'b1;
      step();
    end
    chk("lsb.end_valid", l.ser_valid, 1'b0);
    chk("lsb.end_busy",  l.busy,      1'b0);
    chk("lsb.end_out",   l.ser_out,   1'b0);
    l.shift_en = 1'b0;

    // Back-to-back F0 then 0F with no gap.
    m.in_valid = 1'b1;
    m.in_data  = 8'hF0;
    m.shift_en = 1'b1;
    step();
    m.in_data  = 8'h0F;
    for (int i = 0; i < 2 * FRAME; i++) begin
      chk($sformatf("b2b.valid%0d", i), m.ser_valid, 1'b1);
      chk($sformatf("b2b.out%0d", i),   m.ser_out,
          exp_bit((i < FRAME) ? 8'hF0 : 8'h0F, 1'b1, i % FRAME));
      chk($sformatf("b2b.last%0d", i),  m.ser_last,  ((i % FRAME) == FRAME - 1));
      chk($sformatf("b2b.ready%0d", i), m.in_ready,  ((i % FRAME) == FRAME - 1));
      if (i == FRAME) m.in_valid = 1'b0;
      step();
    end
    chk_m_idle("b2b.end");
    m.shift_en = 1'b0;
    step();

    // Abort FF after three bits, then a clean 81 frame.
    m.in_valid = 1'b1;
    m.in_data  = 8'hFF;
    m.shift_en = 1'b1;
    step();
    m.in_valid = 1'b0;
    chk("abort.valid0", m.ser_valid, 1'b1);
    step();
    step();
    chk("abort.out2", m.ser_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_m_idle("abort.async");
    #1;
    rst = 1'b0;
    m.shift_en = 1'b0;
    step();
    chk_m_idle("abort.after");
    m_frame("msb_81", 8'h81);

`ifdef PIS_PARITY_EN
    m_frame("par_07", 8'h07);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
